memory_responder: RTL and testbench
===================================

Name: memory_responder

Overview:
- Memory-side responder for the instruction decoder's control strobes.
- Each cycle it samples the decoder's memory/IP/IR/raw-bus control lines and owns the instruction pointer (IP).
- It runs one single-port SRAM transaction per accepted command and routes read data to the IR and/or raw bus 0/1 registers.
- It asserts stall while a transaction is in flight so the IR register upstream holds.

Parameters:
- DATA_WIDTH, 8, width of SRAM data, IR and raw bus words.
- ADDR_WIDTH, 8, width of IP, operand address and SRAM address.
- TIMEOUT, 15, maximum cycles waiting for i_sram_ack before abort; range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- i_memory_address_source  input  1  0: address = IP; 1: address = i_operand_address
- i_memory_read_enable  input  1  read command request
- i_memory_write_enable  input  1  write command request
- i_hold_ip_flag  input  1  IP not advanced on completion
- i_reset_ip  input  1  force IP to 0, abort any transaction
- i_select_jump_address  input  1  completion may load IP from read data
- i_jump_condition  input  1  jump taken when high together with select_jump_address
- i_ir_enable  input  1  route read data to o_ir
- i_raw_bus_0_wen  input  1  route read data to o_raw_bus_0
- i_raw_bus_1_wen  input  1  route read data to o_raw_bus_1
- i_operand_address  input  ADDR_WIDTH  operand address
- i_write_data  input  DATA_WIDTH  write data
- o_sram_req  output  1  SRAM request, held until ack
- o_sram_we  output  1  SRAM write select
- o_sram_addr  output  ADDR_WIDTH  SRAM address, stable while req
- o_sram_wdata  output  DATA_WIDTH  SRAM write data, stable while req
- i_sram_ack  input  1  SRAM completion, single cycle
- i_sram_rdata  input  DATA_WIDTH  read data, valid with ack
- o_ip  output  ADDR_WIDTH  instruction pointer
- o_ir  output  DATA_WIDTH  instruction register value
- o_raw_bus_0  output  DATA_WIDTH  raw bus 0 register
- o_raw_bus_1  output  DATA_WIDTH  raw bus 1 register
- o_stall  output  1  transaction in flight
- o_error  output  1  one-cycle pulse on timeout or illegal command

Behaviour:
- Reset (rst_n low at edge): all outputs 0; state IDLE; timeout counter 0. Reset overrides everything, including a mid-transaction ack.
- States: IDLE, BUSY.
- IDLE, with i_reset_ip high:
  - IP <= 0; no transaction starts.
  - reset_ip has priority over every other input in every state.
- IDLE, with read_enable xor write_enable high:
  - Latch the command: address (per address_source), we, wdata, and the ir/bus0/bus1 route, hold and jump-select flags.
  - Go to BUSY; o_sram_req rises the next cycle.
- IDLE, with read and write both high: o_error pulses; no access; IP unchanged.
- IDLE, with neither enable high: IP unchanged; idle.
- BUSY:
  - o_stall = 1; o_sram_req = 1; addr, we and wdata held from the latch.
  - Live decoder inputs are ignored, except i_reset_ip.
- BUSY, with ack sampled high:
  - Read: each latched route (ir, bus0, bus1) loads i_sram_rdata. Multiple routes may load the same word.
  - Write: no register is loaded.
  - IP update: if hold, unchanged; else if jump-select and i_jump_condition (sampled at ack), IP <= i_sram_rdata[ADDR_WIDTH-1:0] (write: no jump, plain increment); else IP <= IP+1, wrapping all-ones to 0.
  - Return to IDLE; o_sram_req falls the cycle after ack.
- BUSY, i_reset_ip high: abort; IP <= 0; IDLE; no data routed; a later ack is ignored.
- Timeout: the counter increments each BUSY cycle without ack.
  - On reaching TIMEOUT: abort to IDLE, o_error pulse, IP and data registers unchanged.
  - Ack in the same cycle as the limit: the ack wins.
- Ack in IDLE: ignored.
- Latency: command at edge N; req high in cycle N+1. Ack at edge M (M ≥ N+1) updates the registers at edge M; o_stall low from M. Minimum access is 2 cycles.
- o_error is a single-cycle pulse.
- Register-only outputs; no combinational path from the decoder inputs to the SRAM outputs.

Decomposition:
- Shared define file holds DATA_WIDTH/ADDR_WIDTH defaults and the state encodings IDLE=1'b0, BUSY=1'b1.
- One natural sub-module, ip_counter: IP register with reset, hold, load and wrapping increment.

Test Plan:
- IP=0x05, read, source 0, ir_enable; ack after 3 cycles with rdata 0xA7 -> o_sram_addr=0x05, o_stall high 3 cycles, o_ir=0xA7, IP=0x06.
- Read, source 1, operand 0x40, raw_bus_1_wen, hold=1; ack rdata 0x3C -> addr 0x40, o_raw_bus_1=0x3C, o_ir unchanged, IP unchanged.
- IP=0x10, select_jump and condition high, ack rdata 0x80 -> IP=0x80; repeat with condition low -> IP=0x11.
- IP=0xFF, read, no hold -> IP wraps to 0x00.
- TIMEOUT=15, no ack -> req falls after 15 BUSY cycles, o_error one cycle, IP unchanged. Second run: ack on cycle 15 -> completes, no error.
- Read and write both high -> o_error pulse, no req. In BUSY, reset_ip high then ack next cycle -> IP=0x00, ack ignored, o_ir unchanged. rst_n low mid-BUSY -> all outputs 0 after the edge.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// rtl/memory_responder_pkg.sv - shared widths, state encoding and command types for memory_responder
package memory_responder_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_ADDR_WIDTH = 8;
   localparam int DEFAULT_TIMEOUT    = 15;

   // Wide enough for any TIMEOUT in 1..255
   localparam int TMO_CNT_WIDTH = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Per-command routing and IP-update flags captured when a command is accepted
   typedef struct packed {
      logic ir;
      logic bus0;
      logic bus1;
      logic hold;
      logic jump_sel;
   } route_t;

   // A command is legal only when exactly one of read/write is requested
   function automatic logic is_single_command(input logic rd, input logic wr);
      return rd ^ wr;
   endfunction

endpackage

// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - single-port SRAM request/ack bus between responder and memory
interface memory_responder_if
   import memory_responder_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ack;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );

endinterface

// File: rtl/memory_responder_ip_counter.sv
// rtl/memory_responder_ip_counter.sv - instruction pointer register with clear, load and wrapping increment
module memory_responder_ip_counter
   import memory_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_value,
   input  logic                  inc,
   output logic [ADDR_WIDTH-1:0] ip
);

   // Clear beats load beats increment; increment wraps naturally at all-ones
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ip <= '0;
      end else if (clear) begin
         ip <= '0;
      end else if (load) begin
         ip <= load_value;
      end else if (inc) begin
         ip <= ip + 1'b1;
      end
   end

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - decoder-driven SRAM responder owning IP, IR and raw bus registers
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_memory_address_source,
   input  logic                  i_memory_read_enable,
   input  logic                  i_memory_write_enable,
   input  logic                  i_hold_ip_flag,
   input  logic                  i_reset_ip,
   input  logic                  i_select_jump_address,
   input  logic                  i_jump_condition,
   input  logic                  i_ir_enable,
   input  logic                  i_raw_bus_0_wen,
   input  logic                  i_raw_bus_1_wen,
   input  logic [ADDR_WIDTH-1:0] i_operand_address,
   input  logic [DATA_WIDTH-1:0] i_write_data,
   memory_responder_if.master    sram,
   output logic [ADDR_WIDTH-1:0] o_ip,
   output logic [DATA_WIDTH-1:0] o_ir,
   output logic [DATA_WIDTH-1:0] o_raw_bus_0,
   output logic [DATA_WIDTH-1:0] o_raw_bus_1,
   output logic                  o_stall,
   output logic                  o_error
);

   localparam logic [TMO_CNT_WIDTH-1:0] TMO_LAST = TMO_CNT_WIDTH'(TIMEOUT - 1);

   state_t                     state_q;
   state_t                     state_d;
   logic [TMO_CNT_WIDTH-1:0]   tmo_cnt_q;
   logic [ADDR_WIDTH-1:0]      addr_q;
   logic [DATA_WIDTH-1:0]      wdata_q;
   logic                       we_q;
   route_t                     route_q;
   logic                       error_q;
   logic                       busy_req;

   logic                       cmd_valid;
   logic                       cmd_illegal;
   logic                       accept;
   logic                       ack_take;
   logic                       tmo_fire;
   logic                       ip_load;
   logic                       ip_inc;

   assign cmd_valid   = is_single_command(i_memory_read_enable, i_memory_write_enable);
   assign cmd_illegal = i_memory_read_enable & i_memory_write_enable;

   // reset_ip suppresses both command acceptance and ack handling
   assign accept   = (state_q == ST_IDLE) && !i_reset_ip && cmd_valid;
   assign ack_take = (state_q == ST_BUSY) && !i_reset_ip && sram.ack;
   // An ack on the limit cycle completes the access instead of timing out
   assign tmo_fire = (state_q == ST_BUSY) && !i_reset_ip && !sram.ack && (tmo_cnt_q == TMO_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: accept a legal command, leave BUSY on reset_ip, ack or timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (i_reset_ip || sram.ack || (tmo_cnt_q == TMO_LAST)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the state register only, so no decoder-to-SRAM path exists
   always_comb begin
      busy_req = 1'b0;
      o_stall  = 1'b0;
      if (state_q == ST_BUSY) begin
         busy_req = 1'b1;
         o_stall  = 1'b1;
      end
   end

   // Counts BUSY cycles without ack; cleared whenever the access ends or has not started
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
      end else if ((state_q == ST_BUSY) && (state_d == ST_BUSY)) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
         tmo_cnt_q <= '0;
      end
   end

   // Command latch: SRAM address/data/direction and routing held for the whole access
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         route_q <= '0;
      end else if (accept) begin
         addr_q           <= i_memory_address_source ? i_operand_address : o_ip;
         wdata_q          <= i_write_data;
         we_q             <= i_memory_write_enable;
         route_q.ir       <= i_ir_enable;
         route_q.bus0     <= i_raw_bus_0_wen;
         route_q.bus1     <= i_raw_bus_1_wen;
         route_q.hold     <= i_hold_ip_flag;
         route_q.jump_sel <= i_select_jump_address;
      end
   end

   // Read data lands in every register its command routed it to
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_ir        <= '0;
         o_raw_bus_0 <= '0;
         o_raw_bus_1 <= '0;
      end else if (ack_take && !we_q) begin
         if (route_q.ir) begin
            o_ir <= sram.rdata;
         end
         if (route_q.bus0) begin
            o_raw_bus_0 <= sram.rdata;
         end
         if (route_q.bus1) begin
            o_raw_bus_1 <= sram.rdata;
         end
      end
   end

   // One-cycle error pulse for a read+write request or an access that timed out
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         error_q <= 1'b0;
      end else begin
         error_q <= ((state_q == ST_IDLE) && !i_reset_ip && cmd_illegal) || tmo_fire;
      end
   end

   // Jumps only happen on reads; writes with jump-select still just increment
   assign ip_load = ack_take && !route_q.hold && route_q.jump_sel && i_jump_condition && !we_q;
   assign ip_inc  = ack_take && !route_q.hold && !ip_load;

   memory_responder_ip_counter #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ip_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (i_reset_ip),
      .load       (ip_load),
      .load_value (sram.rdata[ADDR_WIDTH-1:0]),
      .inc        (ip_inc),
      .ip         (o_ip)
   );

   assign sram.req   = busy_req;
   assign sram.we    = we_q;
   assign sram.addr  = addr_q;
   assign sram.wdata = wdata_q;
   assign o_error    = error_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - randomized self-checking bench for memory_responder
module tb_memory_responder;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          addr_src, rd_en, wr_en, hold_ip, reset_ip, sel_jump, jump_cond;
   logic          ir_en, b0_wen, b1_wen;
   logic [AW-1:0] op_addr;
   logic [DW-1:0] wdata;
   logic [AW-1:0] ip;
   logic [DW-1:0] ir, bus0, bus1;
   logic          stall, error;

   int total = 0;
   int bad   = 0;

   int exp_ip, exp_ir, exp_b0, exp_b1;

   memory_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sram_bus ();

   memory_responder #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .TIMEOUT    (TO)
   ) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .i_memory_address_source (addr_src),
      .i_memory_read_enable    (rd_en),
      .i_memory_write_enable   (wr_en),
      .i_hold_ip_flag          (hold_ip),
      .i_reset_ip              (reset_ip),
      .i_select_jump_address   (sel_jump),
      .i_jump_condition        (jump_cond),
      .i_ir_enable             (ir_en),
      .i_raw_bus_0_wen         (b0_wen),
      .i_raw_bus_1_wen         (b1_wen),
      .i_operand_address       (op_addr),
      .i_write_data            (wdata),
      .sram                    (sram_bus),
      .o_ip                    (ip),
      .o_ir                    (ir),
      .o_raw_bus_0             (bus0),
      .o_raw_bus_1             (bus1),
      .o_stall                 (stall),
      .o_error                 (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      addr_src = 1'b0; rd_en = 1'b0; wr_en = 1'b0; hold_ip = 1'b0; reset_ip = 1'b0;
      sel_jump = 1'b0; jump_cond = 1'b0; ir_en = 1'b0; b0_wen = 1'b0; b1_wen = 1'b0;
      op_addr = '0; wdata = '0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_ip"},   ip,   exp_ip);
      check({tag, "_ir"},   ir,   exp_ir);
      check({tag, "_bus0"}, bus0, exp_b0);
      check({tag, "_bus1"}, bus1, exp_b1);
   endtask

   // One command from acceptance to completion; delay is the ack cycle (1 = first BUSY cycle),
   // a delay beyond TO means the SRAM never answers.
   task automatic run_txn(input bit t_we, input bit src, input int op, input int wd,
                          input bit r_ir, input bit r_b0, input bit r_b1, input bit hold,
                          input bit sel, input bit cond, input int delay, input int rd);
      int  n_busy;
      bit  timed_out;
      int  exp_addr;
      timed_out = (delay > TO);
      n_busy    = timed_out ? TO : delay;
      exp_addr  = src ? op : exp_ip;
      @(negedge clk);
      rd_en = !t_we; wr_en = t_we; addr_src = src; op_addr = AW'(op); wdata = DW'(wd);
      ir_en = r_ir; b0_wen = r_b0; b1_wen = r_b1; hold_ip = hold; sel_jump = sel;
      @(posedge clk); #1;
      // Decoder keeps moving while the access is in flight; only reset_ip may matter
      rd_en = 1'($urandom); wr_en = 1'($urandom); addr_src = 1'($urandom);
      op_addr = AW'($urandom); wdata = DW'($urandom); ir_en = 1'($urandom);
      b0_wen = 1'($urandom); b1_wen = 1'($urandom); hold_ip = 1'($urandom);
      sel_jump = 1'($urandom); jump_cond = 1'($urandom);
      for (int k = 1; k <= n_busy; k++) begin
         @(negedge clk);
         check("busy_req",   sram_bus.req,  1);
         check("busy_stall", stall,         1);
         check("busy_addr",  sram_bus.addr, exp_addr);
         check("busy_we",    sram_bus.we,   t_we);
         if (t_we) check("busy_wdata", sram_bus.wdata, wd);
         if (k == delay) begin
            sram_bus.ack   = 1'b1;
            sram_bus.rdata = DW'(rd);
            jump_cond      = cond;
         end
         @(posedge clk); #1;
         sram_bus.ack   = 1'b0;
         sram_bus.rdata = DW'($urandom);
      end
      idle_inputs();
      if (!timed_out) begin
         if (!t_we) begin
            if (r_ir) exp_ir = rd;
            if (r_b0) exp_b0 = rd;
            if (r_b1) exp_b1 = rd;
         end
         if (!hold) begin
            if (sel && cond && !t_we) exp_ip = rd % 256;
            else                      exp_ip = (exp_ip + 1) % 256;
         end
      end
      @(negedge clk);
      check("done_req",   sram_bus.req, 0);
      check("done_stall", stall,        0);
      check("done_error", error,        timed_out);
      check_regs("done");
      @(negedge clk);
      check("error_pulse_width", error, 0);
   endtask

   task automatic illegal_cmd();
      @(negedge clk);
      rd_en = 1'b1; wr_en = 1'b1; ir_en = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("illegal_error", error,        1);
      check("illegal_req",   sram_bus.req, 0);
      check("illegal_stall", stall,        0);
      check("illegal_ip",    ip,           exp_ip);
      @(negedge clk);
      check("illegal_error_clear", error,        0);
      check("illegal_req_later",   sram_bus.req, 0);
   endtask

   task automatic ack_in_idle();
      @(negedge clk);
      sram_bus.ack = 1'b1; sram_bus.rdata = 8'hE1;
      @(posedge clk); #1;
      sram_bus.ack = 1'b0;
      @(negedge clk);
      check("idle_ack_req", sram_bus.req, 0);
      check_regs("idle_ack");
   endtask

   task automatic reset_ip_idle();
      @(negedge clk);
      reset_ip = 1'b1; rd_en = 1'b1; wr_en = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      exp_ip = 0;
      @(negedge clk);
      check("rip_idle_error", error,        0);
      check("rip_idle_req",   sram_bus.req, 0);
      check("rip_idle_ip",    ip,           exp_ip);
   endtask

   task automatic reset_ip_busy();
      @(negedge clk);
      rd_en = 1'b1; ir_en = 1'b1; b0_wen = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("rip_busy_req", sram_bus.req, 1);
      reset_ip = 1'b1;
      @(posedge clk); #1;
      reset_ip = 1'b0;
      exp_ip = 0;
      @(negedge clk);
      check("rip_abort_req",   sram_bus.req, 0);
      check("rip_abort_stall", stall,        0);
      sram_bus.ack = 1'b1; sram_bus.rdata = 8'h5A;
      @(posedge clk); #1;
      sram_bus.ack = 1'b0;
      @(negedge clk);
      check("rip_late_ack_error", error, 0);
      check_regs("rip_late_ack");
   endtask

   task automatic reset_mid_busy();
      @(negedge clk);
      rd_en = 1'b1; b1_wen = 1'b1; addr_src = 1'b1; op_addr = 8'hC3;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("rst_busy_req", sram_bus.req, 1);
      rst_n = 1'b0; sram_bus.ack = 1'b1; sram_bus.rdata = 8'h77;
      @(posedge clk); #1;
      sram_bus.ack = 1'b0;
      exp_ip = 0; exp_ir = 0; exp_b0 = 0; exp_b1 = 0;
      @(negedge clk);
      check("rst_req",   sram_bus.req,   0);
      check("rst_we",    sram_bus.we,    0);
      check("rst_addr",  sram_bus.addr,  0);
      check("rst_wdata", sram_bus.wdata, 0);
      check("rst_stall", stall,          0);
      check("rst_error", error,          0);
      check_regs("rst");
      rst_n = 1'b1;
   endtask

   initial begin
      idle_inputs();
      sram_bus.ack   = 1'b0;
      sram_bus.rdata = '0;
      rst_n = 1'b0;
      exp_ip = 0; exp_ir = 0; exp_b0 = 0; exp_b1 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_req",   sram_bus.req,   0);
      check("reset_we",    sram_bus.we,    0);
      check("reset_addr",  sram_bus.addr,  0);
      check("reset_wdata", sram_bus.wdata, 0);
      check("reset_stall", stall,          0);
      check("reset_error", error,          0);
      check_regs("reset");
      rst_n = 1'b1;

      // Walk IP up to 0x05 with plain writes
      for (int i = 0; i < 5; i++) run_txn(1, 0, 0, 8'h10 + i, 0, 0, 0, 0, 0, 0, 1, 8'hFF);
      run_txn(0, 0, 0,     0, 1, 0, 0, 0, 0, 0, 3, 8'hA7);
      run_txn(0, 1, 8'h40, 0, 0, 0, 1, 1, 0, 0, 2, 8'h3C);

      // Jump to 0x0F, step to 0x10, jump taken / not taken
      run_txn(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h0F);
      run_txn(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h21);
      run_txn(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 2, 8'h80);
      run_txn(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h10);
      run_txn(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8'h99);
      // Write with jump-select and condition still increments
      run_txn(1, 0, 0, 8'h5C, 0, 0, 0, 0, 1, 1, 1, 8'h33);
      // Wrap from 0xFF
      run_txn(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'hFF);
      run_txn(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 8'h6E);

      // Timeout versus ack on the limit cycle
      run_txn(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, TO + 1, 8'hBD);
      run_txn(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, TO,     8'hBD);

      illegal_cmd();
      ack_in_idle();
      reset_ip_idle();
      reset_ip_busy();

      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom), 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(1, TO + 3), $urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) illegal_cmd();
      end

      reset_mid_busy();
      run_txn(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'h42);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d", total);
      $fatal(1, "watchdog");
   end

endmodule
